// File: rtl/csr_regfile_if.sv
// CSR access bus between the pipeline (master) and the CSR register file (slave).
// The EX side carries the combinational read port; the WB side carries the write
// port and the instruction-retire strobe.
interface csr_regfile_if;
   logic [11:0] csr_addr_EX;
   logic [31:0] csr_rdata_EX;
   logic        csr_illegal_EX;
   logic        csr_we_WB;
   logic [11:0] csr_addr_WB;
   logic [31:0] csr_data_WB;
   logic        instr_retire;

   modport master (
      output csr_addr_EX, csr_we_WB, csr_addr_WB, csr_data_WB, instr_retire,
      input  csr_rdata_EX, csr_illegal_EX
   );

   modport slave (
      input  csr_addr_EX, csr_we_WB, csr_addr_WB, csr_data_WB, instr_retire,
      output csr_rdata_EX, csr_illegal_EX
   );
endinterface

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file with a combinational EX read port, a WB write
// port and WB->EX bypass. Optional 64-bit mcycle/minstret counters (and their
// read-only user aliases) are built only when CSR_COUNTERS_EN is defined;
// otherwise the counter addresses read as zero, are legal, and ignore writes.
module csr_regfile #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input logic          clk,
   input logic          rst,
   csr_regfile_if.slave bus
);

   localparam logic [11:0] AddrBubble   = 12'h000;
   localparam logic [11:0] AddrMstatus  = 12'h300;
   localparam logic [11:0] AddrMie      = 12'h304;
   localparam logic [11:0] AddrMtvec    = 12'h305;
   localparam logic [11:0] AddrMscratch = 12'h340;
   localparam logic [11:0] AddrMepc     = 12'h341;
   localparam logic [11:0] AddrMcause   = 12'h342;
   localparam logic [11:0] AddrMcycle   = 12'hB00;
   localparam logic [11:0] AddrMcycleh  = 12'hB80;
   localparam logic [11:0] AddrMinstret = 12'hB02;
   localparam logic [11:0] AddrMinstreth = 12'hB82;
   localparam logic [11:0] AddrCycle    = 12'hC00;
   localparam logic [11:0] AddrCycleh   = 12'hC80;
   localparam logic [11:0] AddrInstret  = 12'hC02;
   localparam logic [11:0] AddrInstreth = 12'hC82;

   // mtvec and mepc are word-aligned; low two bits never hold a one.
   function automatic logic [31:0] wmask(input logic [11:0] addr, input logic [31:0] data);
      if (addr == AddrMtvec || addr == AddrMepc) return {data[31:2], 2'b00};
      return data;
   endfunction

   // Addresses that accept a write (and therefore can be bypassed).
   function automatic logic writable(input logic [11:0] addr);
      case (addr)
         AddrMstatus, AddrMie, AddrMtvec, AddrMscratch, AddrMepc, AddrMcause: return 1'b1;
`ifdef CSR_COUNTERS_EN
         AddrMcycle, AddrMcycleh, AddrMinstret, AddrMinstreth: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   logic [31:0] mstatus_q, mstatus_d;
   logic [31:0] mie_q, mie_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        illegal;

   assign wdata = wmask(bus.csr_addr_WB, bus.csr_data_WB);

   // Next state of the plain read/write CSRs; bubble and unknown addresses fall through.
   always_comb begin
      mstatus_d  = mstatus_q;
      mie_d      = mie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      if (bus.csr_we_WB) begin
         case (bus.csr_addr_WB)
            AddrMstatus:  mstatus_d  = wdata;
            AddrMie:      mie_d      = wdata;
            AddrMtvec:    mtvec_d    = wdata;
            AddrMscratch: mscratch_d = wdata;
            AddrMepc:     mepc_d     = wdata;
            AddrMcause:   mcause_d   = wdata;
            default: ;
         endcase
      end
   end

   // CSR state with synchronous reset; mtvec resets to its aligned reset vector.
   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus_q  <= '0;
         mie_q      <= '0;
         mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
      end else begin
         mstatus_q  <= mstatus_d;
         mie_q      <= mie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
      end
   end

`ifdef CSR_COUNTERS_EN
   logic [63:0] mcycle_q, mcycle_d;
   logic [63:0] minstret_q, minstret_d;

   // Counter next state: a write to either half wins over the increment that cycle.
   always_comb begin
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = bus.instr_retire ? minstret_q + 64'd1 : minstret_q;
      if (bus.csr_we_WB) begin
         case (bus.csr_addr_WB)
            AddrMcycle:    mcycle_d   = {mcycle_q[63:32], bus.csr_data_WB};
            AddrMcycleh:   mcycle_d   = {bus.csr_data_WB, mcycle_q[31:0]};
            AddrMinstret:  minstret_d = {minstret_q[63:32], bus.csr_data_WB};
            AddrMinstreth: minstret_d = {bus.csr_data_WB, minstret_q[31:0]};
            default: ;
         endcase
      end
   end

   // Counter state with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end
`else
   logic unused_instr_retire;
   assign unused_instr_retire = bus.instr_retire;
`endif

   // Combinational read port with same-cycle WB bypass of the masked write data.
   always_comb begin
      rdata   = '0;
      illegal = 1'b0;
      case (bus.csr_addr_EX)
         AddrBubble:   ;
         AddrMstatus:  rdata = mstatus_q;
         AddrMie:      rdata = mie_q;
         AddrMtvec:    rdata = mtvec_q;
         AddrMscratch: rdata = mscratch_q;
         AddrMepc:     rdata = mepc_q;
         AddrMcause:   rdata = mcause_q;
`ifdef CSR_COUNTERS_EN
         AddrMcycle,    AddrCycle:    rdata = mcycle_q[31:0];
         AddrMcycleh,   AddrCycleh:   rdata = mcycle_q[63:32];
         AddrMinstret,  AddrInstret:  rdata = minstret_q[31:0];
         AddrMinstreth, AddrInstreth: rdata = minstret_q[63:32];
`else
         AddrMcycle, AddrCycle, AddrMcycleh, AddrCycleh,
         AddrMinstret, AddrInstret, AddrMinstreth, AddrInstreth: rdata = '0;
`endif
         default: illegal = 1'b1;
      endcase
      if (bus.csr_we_WB && (bus.csr_addr_WB == bus.csr_addr_EX) && writable(bus.csr_addr_WB)) begin
         rdata = wdata;
      end
   end

   assign bus.csr_rdata_EX   = rdata;
   assign bus.csr_illegal_EX = illegal;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed-vector bench for csr_regfile. The driver applies one vector per cycle
// and queues the expected read response; a monitor on the falling edge pops and
// compares. Counter expectations follow whether CSR_COUNTERS_EN is defined.
module tb_csr_regfile;

`ifdef CSR_COUNTERS_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   string       name_q[$];
   logic [31:0] rdata_q[$];
   logic        illegal_q[$];

   csr_regfile_if bus ();

   csr_regfile #(
      .MTVEC_RESET(32'h8000_0100)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one vector just after the rising edge.
   task automatic cyc(input logic r, input logic we, input logic [11:0] wa,
                      input logic [31:0] wd, input logic [11:0] ra, input logic ret);
      @(posedge clk);
      #1;
      rst              = r;
      bus.csr_we_WB    = we;
      bus.csr_addr_WB  = wa;
      bus.csr_data_WB  = wd;
      bus.csr_addr_EX  = ra;
      bus.instr_retire = ret;
   endtask

   task automatic expect_rd(input string n, input logic [31:0] d, input logic il);
      name_q.push_back(n);
      rdata_q.push_back(d);
      illegal_q.push_back(il);
   endtask

   // Monitor: compare the read port once per cycle when a response is expected.
   always @(negedge clk) begin
      string       n;
      logic [31:0] d;
      logic        il;
      if (name_q.size() > 0) begin
         n  = name_q.pop_front();
         d  = rdata_q.pop_front();
         il = illegal_q.pop_front();
         vectors++;
         if (bus.csr_rdata_EX !== d || bus.csr_illegal_EX !== il) begin
            miscompares++;
            $display("FAIL %s: got rdata=%h illegal=%b, want rdata=%h illegal=%b",
                     n, bus.csr_rdata_EX, bus.csr_illegal_EX, d, il);
         end
      end
   end

   initial begin
      vectors          = 0;
      miscompares      = 0;
      rst              = 1'b1;
      bus.csr_we_WB    = 1'b0;
      bus.csr_addr_WB  = 12'h000;
      bus.csr_data_WB  = 32'h0;
      bus.csr_addr_EX  = 12'h000;
      bus.instr_retire = 1'b0;

      // Reset state, readable while reset is still asserted.
      cyc(1, 0, 12'h000, 32'h0, 12'h305, 0); expect_rd("rst_mtvec", 32'h8000_0100, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'hB00, 0); expect_rd("rst_mcycle", 32'h0, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'hB00, 0); expect_rd("mcycle_first", CntEn ? 32'h1 : 32'h0, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'h341, 0); expect_rd("rst_mepc", 32'h0, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'h300, 0); expect_rd("rst_mstatus", 32'h0, 0);

      // Plain CSR writes, masking and bypass.
      cyc(0, 1, 12'h341, 32'h0000_1237, 12'h341, 0); expect_rd("mepc_bypass", 32'h0000_1234, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'h341, 0);          expect_rd("mepc_held", 32'h0000_1234, 0);
      cyc(0, 1, 12'h305, 32'h0000_2003, 12'h305, 0); expect_rd("mtvec_bypass", 32'h0000_2000, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'h305, 0);          expect_rd("mtvec_held", 32'h0000_2000, 0);
      cyc(0, 1, 12'h300, 32'hA5A5_A5A5, 12'h340, 0); expect_rd("no_cross_bypass", 32'h0, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'h300, 0);          expect_rd("mstatus_held", 32'hA5A5_A5A5, 0);
      cyc(0, 1, 12'h340, 32'hFFFF_FFFF, 12'h340, 0); expect_rd("mscratch_bypass", 32'hFFFF_FFFF, 0);
      cyc(0, 1, 12'h342, 32'h8000_000B, 12'h342, 0); expect_rd("mcause_bypass", 32'h8000_000B, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'h304, 0);          expect_rd("mie_reset", 32'h0, 0);
      cyc(0, 1, 12'h304, 32'h0000_0888, 12'h342, 0); expect_rd("mcause_held", 32'h8000_000B, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'h304, 0);          expect_rd("mie_held", 32'h0000_0888, 0);

      // Bubble and unimplemented addresses.
      cyc(0, 1, 12'h000, 32'hDEAD_BEEF, 12'h7FF, 0); expect_rd("illegal_7ff", 32'h0, 1);
      cyc(0, 1, 12'h7FF, 32'h0000_0001, 12'h7FF, 0); expect_rd("illegal_no_bypass", 32'h0, 1);
      cyc(0, 0, 12'h000, 32'h0, 12'h000, 0);          expect_rd("bubble_read", 32'h0, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'h301, 0);          expect_rd("illegal_301", 32'h0, 1);
      cyc(0, 0, 12'h000, 32'h0, 12'h340, 0);          expect_rd("mscratch_after_bubble", 32'hFFFF_FFFF, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'h341, 0);          expect_rd("mepc_after_bubble", 32'h0000_1234, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'h305, 0);          expect_rd("mtvec_after_bubble", 32'h0000_2000, 0);

      // mcycle carry across halves.
      cyc(0, 1, 12'hB00, 32'hFFFF_FFFE, 12'hB00, 0); expect_rd("mcycle_lo_bypass", CntEn ? 32'hFFFF_FFFE : 32'h0, 0);
      cyc(0, 1, 12'hB80, 32'h0, 12'hB80, 0);          expect_rd("mcycle_hi_bypass", 32'h0, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'hB00, 0);          expect_rd("mcycle_no_inc", CntEn ? 32'hFFFF_FFFE : 32'h0, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'hB00, 0);          expect_rd("mcycle_ffff", CntEn ? 32'hFFFF_FFFF : 32'h0, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'hB00, 0);          expect_rd("mcycle_wrap_lo", 32'h0, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'hC80, 0);          expect_rd("cycleh_carry", CntEn ? 32'h1 : 32'h0, 0);
      cyc(0, 1, 12'hC00, 32'h0000_1234, 12'hC00, 0); expect_rd("cycle_ro_no_bypass", CntEn ? 32'h2 : 32'h0, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'hB00, 0);          expect_rd("cycle_ro_ignored", CntEn ? 32'h3 : 32'h0, 0);

      // minstret: retire for 5 cycles, counter write on the third.
      cyc(0, 0, 12'h000, 32'h0, 12'hB02, 1);          expect_rd("minstret_r1", 32'h0, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'hB02, 1);          expect_rd("minstret_r2", CntEn ? 32'd1 : 32'h0, 0);
      cyc(0, 1, 12'hB02, 32'd100, 12'hB02, 1);        expect_rd("minstret_wr_bypass", CntEn ? 32'd100 : 32'h0, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'hB02, 1);          expect_rd("minstret_r4", CntEn ? 32'd100 : 32'h0, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'hB02, 1);          expect_rd("minstret_r5", CntEn ? 32'd101 : 32'h0, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'hC02, 0);          expect_rd("instret_final", CntEn ? 32'd102 : 32'h0, 0);
      cyc(0, 1, 12'hB82, 32'h7, 12'hB82, 0);          expect_rd("minstreth_bypass", CntEn ? 32'h7 : 32'h0, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'hB02, 0);          expect_rd("minstret_lo_kept", CntEn ? 32'd102 : 32'h0, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'hC82, 0);          expect_rd("instreth_alias", CntEn ? 32'h7 : 32'h0, 0);

      // Counter write in either build; disabled build reads zero and stays legal.
      cyc(0, 1, 12'hB00, 32'h55, 12'hB00, 0);         expect_rd("b00_write", CntEn ? 32'h55 : 32'h0, 0);
      cyc(0, 0, 12'h000, 32'h0, 12'hB00, 0);          expect_rd("b00_after", CntEn ? 32'h55 : 32'h0, 0);

      // Drain the scoreboard with a bounded wait.
      cyc(0, 0, 12'h000, 32'h0, 12'h000, 0);
      for (int i = 0; i < 20 && name_q.size() > 0; i++) @(negedge clk);
      if (name_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending responses, want 0", name_q.size());
      end
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/csr_regfile.md
CSR_REGFILE -- requirements
Module: csr_regfile

Interface
REQ-001 SHALL have parameter MTVEC_RESET, default 32'h0000_0000, reset value of mtvec.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port csr_addr_EX  input  12  read address from EX stage.
REQ-005 SHALL have port csr_rdata_EX  output  32  combinational read data for csr_addr_EX.
REQ-006 SHALL have port csr_illegal_EX  output  1  high when csr_addr_EX is not an implemented CSR.
REQ-007 SHALL have port csr_we_WB  input  1  write enable from WB stage.
REQ-008 SHALL have port csr_addr_WB  input  12  write address from WB stage.
REQ-009 SHALL have port csr_data_WB  input  32  write data from WB stage.
REQ-010 SHALL have port instr_retire  input  1  one instruction retired this cycle.

Function
REQ-011 SHALL implement mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342 as 32-bit read/write registers.
REQ-012 SHALL force mepc[1:0] and mtvec[1:0] to 2'b00 on write and read.
REQ-013 SHALL perform a write at the clock edge when csr_we_WB=1 and csr_addr_WB is implemented; one-cycle write latency.
REQ-014 SHALL ignore writes with csr_addr_WB=12'h000 (flushed bubble) or any unimplemented address; no state change.
REQ-015 SHALL return 32'h0 and assert csr_illegal_EX for unimplemented read addresses; csr_illegal_EX=0 for 12'h000 (bubble).
REQ-016 SHALL bypass: when csr_we_WB=1 and csr_addr_WB==csr_addr_EX (implemented), csr_rdata_EX = masked csr_data_WB in the same cycle.
REQ-017 SHALL, for counter addresses, bypass the written value rather than the incremented value.
REQ-018 SHALL hold 64-bit mcycle (low 0xB00, high 0xB80), incrementing by 1 every non-reset cycle, wrapping 64'hFFFF_FFFF_FFFF_FFFF -> 0.
REQ-019 SHALL hold 64-bit minstret (low 0xB02, high 0xB82), incrementing by 1 when instr_retire=1, same wrap rule.
REQ-020 SHALL give a CSR write to a counter half priority over the increment in that cycle: written half takes csr_data_WB, other half unchanged, no increment.
REQ-021 SHALL carry from low to high half on increment only (0xFFFF_FFFF low -> 0, high +1 in same edge).
REQ-022 SHALL also expose read-only aliases cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82; writes to them ignored.

Reset
REQ-023 SHALL, when rst=1 at a clock edge, set mtvec=MTVEC_RESET and all other CSRs and counters to 0; writes and increments in that cycle discarded.
REQ-024 SHALL resume counting on the first edge with rst=0 (mcycle=1 one cycle after reset release).
REQ-025 SHALL keep csr_rdata_EX/csr_illegal_EX purely combinational, valid during reset (reflecting reset state after first reset edge).

Configuration
REQ-026 SHALL, with macro CSR_COUNTERS_EN defined, implement REQ-018..REQ-022.
REQ-027 SHALL, without CSR_COUNTERS_EN, omit counter storage; counter addresses read 32'h0, writes ignored, csr_illegal_EX=0 for them, instr_retire unused.

Verification
REQ-028 SHALL cover: rst 1 cycle, MTVEC_RESET=32'h8000_0100 -> read 0x305 = 32'h8000_0100, 0x341 = 0.
REQ-029 SHALL cover: we=1 addr 0x341 data 32'h0000_1237, EX reads 0x341 same cycle -> 32'h0000_1234 (bypass, masked); next cycle still 32'h0000_1234.
REQ-030 SHALL cover: we=1 addr 12'h000 data 32'hDEAD_BEEF -> no CSR changes; read 0x7FF -> 0 with csr_illegal_EX=1.
REQ-031 SHALL cover: write 0xB00=32'hFFFF_FFFE, 0xB80=32'h0 -> after 2 free-running cycles low=32'h0, high=32'h1.
REQ-032 SHALL cover: instr_retire=1 for 5 cycles with write 0xB02=32'd100 on cycle 3 -> final minstret low=32'd102.
REQ-033 SHALL cover: build without CSR_COUNTERS_EN, write 0xB00=32'h55 -> read 0xB00=0, csr_illegal_EX=0.
